// File: rtl/timer_regs_pkg.sv
// Shared encodings for the timer_regs block: FSM states, register offsets,
// TAC field positions and the TAC-select to system-counter bit mapping.
package timer_regs_pkg;

    typedef enum logic [1:0] {
        TIMER_REGS_IDLE   = 2'd0,
        TIMER_REGS_RUN    = 2'd1,
        TIMER_REGS_RELOAD = 2'd2
    } timer_state_e;

    localparam logic [1:0] OFS_DIV  = 2'd0;
    localparam logic [1:0] OFS_TIMA = 2'd1;
    localparam logic [1:0] OFS_TMA  = 2'd2;
    localparam logic [1:0] OFS_TAC  = 2'd3;

    localparam int unsigned TAC_EN_BIT  = 2;
    localparam int unsigned TAC_SEL_MSB = 1;
    localparam int unsigned TAC_SEL_LSB = 0;

    localparam logic [3:0] SEL_BIT_00 = 4'd9;
    localparam logic [3:0] SEL_BIT_01 = 4'd3;
    localparam logic [3:0] SEL_BIT_10 = 4'd5;
    localparam logic [3:0] SEL_BIT_11 = 4'd7;

    function automatic logic [3:0] tac_sel_bit(input logic [1:0] sel);
        logic [3:0] bit_idx;
        case (sel)
            2'b00:   bit_idx = SEL_BIT_00;
            2'b01:   bit_idx = SEL_BIT_01;
            2'b10:   bit_idx = SEL_BIT_10;
            default: bit_idx = SEL_BIT_11;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/timer_edge_sel.sv
// Timer input select from TAC plus falling-edge detect of the selected bit.
// Inputs are the next-state TAC and system counter, so steps, DIV writes and
// TAC writes all produce their edge through the same path.
module timer_edge_sel
    import timer_regs_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  tac_i,
    input  logic [15:0] sys_cnt_i,
    output logic        fall_o
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = tac_i[TAC_EN_BIT]
              & sys_cnt_i[tac_sel_bit(tac_i[TAC_SEL_MSB:TAC_SEL_LSB])];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign fall_o = sig_q & ~sig_d;

endmodule

// File: rtl/timer_regs.sv
// DIV/TIMA/TMA/TAC timer registers advanced by a backlog of retired M-cycles,
// with a one-clock overflow interrupt request (vector 0x50).
module timer_regs
    import timer_regs_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = 16'hFF04,
    parameter int unsigned PEND_W    = 5
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iStepValid,
    input  logic [2:0]  iStepMCycles,
    input  logic [15:0] iAddr,
    input  logic        iWe,
    input  logic [7:0]  iWData,
    output logic [7:0]  oRData,
    output logic        oInterrupt0x50,
    output logic        oOverrun
);

    localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

    timer_state_e      state_q, state_d;
    logic [15:0]       sys_cnt_q, sys_cnt_d;
    logic [7:0]        tima_q, tima_d;
    logic [7:0]        tma_q, tma_d;
    logic [2:0]        tac_q, tac_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovr_q, ovr_d;

    logic [15:0]       ofs_full;
    logic              hit;
    logic [1:0]        ofs;
    logic              we_div, we_tima, we_tma, we_tac;
    logic              step, fall, overflow, irq;
    logic [2:0]        add_mc;
    logic [PEND_W:0]   pend_sum;

    assign ofs_full = iAddr - ADDR_BASE;
    assign hit      = (ofs_full[15:2] == '0);
    assign ofs      = ofs_full[1:0];
    assign we_div   = iWe & hit & (ofs == OFS_DIV);
    assign we_tima  = iWe & hit & (ofs == OFS_TIMA);
    assign we_tma   = iWe & hit & (ofs == OFS_TMA);
    assign we_tac   = iWe & hit & (ofs == OFS_TAC);

    assign step   = (state_q != TIMER_REGS_IDLE) && (pend_q != '0);
    assign add_mc = iStepValid ? iStepMCycles : 3'd0;

    // One spare bit lets the net add/consume be compared against saturation.
    always_comb begin : backlog
        pend_sum = {1'b0, pend_q} + {{(PEND_W-2){1'b0}}, add_mc}
                 - {{PEND_W{1'b0}}, step};
        pend_d   = pend_sum[PEND_W-1:0];
        ovr_d    = ovr_q;
        if (pend_sum > PEND_MAX) begin
            pend_d = '1;
            ovr_d  = 1'b1;
        end
    end

    assign sys_cnt_d = we_div ? '0 : (step ? sys_cnt_q + 16'd4 : sys_cnt_q);
    assign tac_d     = we_tac ? iWData[2:0] : tac_q;
    assign tma_d     = we_tma ? iWData : tma_q;

    timer_edge_sel u_edge (
        .clk_i     (iClock),
        .rst_ni    (iReset_n),
        .tac_i     (tac_d),
        .sys_cnt_i (sys_cnt_d),
        .fall_o    (fall)
    );

    always_comb begin : tima_fsm
        tima_d   = tima_q;
        state_d  = state_q;
        overflow = 1'b0;
        irq      = (state_q == TIMER_REGS_RELOAD) && step && !we_tima;

        // TIMA write beats reload and edge increments; TIMA is held at 0 in RELOAD.
        if (we_tima) begin
            tima_d = iWData;
        end else if (state_q == TIMER_REGS_RELOAD) begin
            if (step) begin
                tima_d = tma_d;
            end
        end else if (fall) begin
            tima_d   = tima_q + 8'd1;
            overflow = (tima_q == 8'hFF);
        end

        unique case (state_q)
            TIMER_REGS_IDLE: begin
                if (overflow) begin
                    state_d = TIMER_REGS_RELOAD;
                end else if ((pend_q != '0) || (iStepValid && (iStepMCycles != '0))) begin
                    state_d = TIMER_REGS_RUN;
                end
            end
            TIMER_REGS_RUN: begin
                if (overflow) begin
                    state_d = TIMER_REGS_RELOAD;
                end else if (pend_d == '0) begin
                    state_d = TIMER_REGS_IDLE;
                end
            end
            TIMER_REGS_RELOAD: begin
                if (we_tima || step) begin
                    state_d = (pend_d != '0) ? TIMER_REGS_RUN : TIMER_REGS_IDLE;
                end
            end
            default: state_d = TIMER_REGS_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= TIMER_REGS_IDLE;
            sys_cnt_q <= '0;
            tima_q    <= '0;
            tma_q     <= '0;
            tac_q     <= '0;
            pend_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sys_cnt_q <= sys_cnt_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin : read_mux
        oRData = 8'hFF;
        if (hit) begin
            case (ofs)
                OFS_DIV:  oRData = sys_cnt_q[15:8];
                OFS_TIMA: oRData = tima_q;
                OFS_TMA:  oRData = tma_q;
                OFS_TAC:  oRData = {5'b11111, tac_q};
                default:  oRData = 8'hFF;
            endcase
        end
    end

    assign oInterrupt0x50 = irq;
    assign oOverrun       = ovr_q;

endmodule

// File: tb/tb_timer_regs.sv
// Bench for timer_regs: directed scenarios plus random traffic, checked
// against a cycle-level arithmetic model of the timer rules.
module tb_timer_regs;

    logic        iClock;
    logic        iReset_n;
    logic        iStepValid;
    logic [2:0]  iStepMCycles;
    logic [15:0] iAddr;
    logic        iWe;
    logic [7:0]  iWData;
    logic [7:0]  oRData;
    logic        oInterrupt0x50;
    logic        oOverrun;

    timer_regs #(.ADDR_BASE(16'hFF04), .PEND_W(5)) dut (
        .iClock         (iClock),
        .iReset_n       (iReset_n),
        .iStepValid     (iStepValid),
        .iStepMCycles   (iStepMCycles),
        .iAddr          (iAddr),
        .iWe            (iWe),
        .iWData         (iWData),
        .oRData         (oRData),
        .oInterrupt0x50 (oInterrupt0x50),
        .oOverrun       (oOverrun)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int passed;
    int checks;
    int irq_seen;

    // Reference model state
    int m_sys, m_tima, m_tma, m_tac, m_pend, m_accepted;
    bit m_reload, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int m_sig(input int tac, input int sys);
        int k;
        if ((tac & 4) == 0) return 0;
        case (tac & 3)
            0:       k = 9;
            1:       k = 3;
            2:       k = 5;
            default: k = 7;
        endcase
        return (sys >> k) & 1;
    endfunction

    function automatic int m_read(input logic [15:0] a);
        case (a)
            16'hFF04: return (m_sys >> 8) & 255;
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return 248 | m_tac;
            default:  return 255;
        endcase
    endfunction

    function automatic int m_irq();
        return (m_reload && m_pend > 0 && !(iWe && iAddr == 16'hFF05)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
        m_reload = 0; m_ovr = 0; m_accepted = 0;
    endtask

    task automatic model_update();
        int step, new_sys, new_tac, new_tma, add, np;
        bit w_div, w_tima, w_tma, w_tac;
        step   = (m_pend > 0) ? 1 : 0;
        w_div  = iWe && iAddr == 16'hFF04;
        w_tima = iWe && iAddr == 16'hFF05;
        w_tma  = iWe && iAddr == 16'hFF06;
        w_tac  = iWe && iAddr == 16'hFF07;
        new_sys = w_div ? 0 : ((m_sys + 4 * step) % 65536);
        new_tac = w_tac ? (int'(iWData) & 7) : m_tac;
        new_tma = w_tma ? int'(iWData) : m_tma;
        if (w_tima) begin
            m_tima = int'(iWData);
            m_reload = 0;
        end else if (m_reload) begin
            if (step == 1) begin
                m_tima = new_tma;
                m_reload = 0;
            end
        end else if (m_sig(m_tac, m_sys) == 1 && m_sig(new_tac, new_sys) == 0) begin
            if (m_tima == 255) begin
                m_tima = 0;
                m_reload = 1;
            end else begin
                m_tima = m_tima + 1;
            end
        end
        add = iStepValid ? int'(iStepMCycles) : 0;
        np  = m_pend + add - step;
        if (np > 31) begin
            np = 31;
            m_ovr = 1;
        end
        m_accepted = m_accepted + (np - m_pend + step);
        m_pend = np;
        m_sys = new_sys;
        m_tac = new_tac;
        m_tma = new_tma;
    endtask

    task automatic tick();
        @(negedge iClock);
        check("rdata",  oRData, m_read(iAddr));
        check("irq",    oInterrupt0x50, m_irq());
        check("ovr",    oOverrun, m_ovr);
        check("syscnt", dut.sys_cnt_q, m_sys);
        check("pend",   dut.pend_q, m_pend);
        if (oInterrupt0x50 === 1'b1) irq_seen++;
        @(posedge iClock);
        model_update();
        #1;
    endtask

    task automatic cyc(input bit v, input int mc, input bit we,
                       input logic [15:0] a, input logic [7:0] d);
        iStepValid   = v;
        iStepMCycles = 3'(mc);
        iWe          = we;
        iAddr        = a;
        iWData       = d;
        tick();
        iStepValid = 1'b0;
        iWe        = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b0, 0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, iAddr, 8'h00);
    endtask

    task automatic feed(input int n);
        int rem, mc;
        rem = n;
        while (rem > 0 || m_pend > 0) begin
            mc = (rem > 7) ? 7 : rem;
            if (m_pend > 20) mc = 0;
            cyc(mc > 0, mc, 1'b0, 16'hFF05, 8'h00);
            rem = rem - mc;
        end
    endtask

    task automatic do_reset();
        iReset_n = 1'b0;
        #1;
        model_reset();
        #1;
        iReset_n = 1'b1;
    endtask

    initial begin
        passed = 0; checks = 0; irq_seen = 0;
        iReset_n = 1'b0; iStepValid = 1'b0; iStepMCycles = 3'd0;
        iAddr = 16'hFF04; iWe = 1'b0; iWData = 8'h00;
        model_reset();
        @(posedge iClock);
        #1;
        do_reset();

        // Reset read-back
        for (int a = 16'hFF04; a <= 16'hFF08; a++) cyc(1'b0, 0, 1'b0, 16'(a), 8'h00);

        // TAC=101, 4 M-cycles: counter 16, one fall of bit 3 (12->16)
        wr(16'hFF07, 8'h05);
        cyc(1'b1, 4, 1'b0, 16'hFF05, 8'h00);
        idle(4);
        check("t1_sys", dut.sys_cnt_q, 16);
        check("t1_tima", oRData, 8'h01);
        iAddr = 16'hFF04; #1;
        check("t1_div", oRData, 8'h00);

        // Overflow at bit 9 after 256 steps, then reload from TMA
        do_reset();
        wr(16'hFF07, 8'h04);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF06, 8'hAB);
        feed(256);
        check("t2_tima0", oRData, 8'h00);
        irq_seen = 0;
        cyc(1'b1, 1, 1'b0, 16'hFF05, 8'h00);
        idle(3);
        check("t2_irq_once", irq_seen, 1);
        check("t2_tima_tma", oRData, 8'hAB);
        check("t2_sys", dut.sys_cnt_q, 1028);

        // TIMA write during RELOAD cancels reload and interrupt
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        feed(4);
        check("t3_tima0", oRData, 8'h00);
        irq_seen = 0;
        wr(16'hFF05, 8'h55);
        cyc(1'b1, 1, 1'b0, 16'hFF05, 8'h00);
        idle(2);
        check("t3_no_irq", irq_seen, 0);
        check("t3_tima", oRData, 8'h55);
        iAddr = 16'hFF06; #1;
        check("t3_tma", oRData, 8'hAB);

        // DIV write glitch with bit 7 high, then with timer disabled
        do_reset();
        wr(16'hFF07, 8'h07);
        feed(32);
        check("t4_sys80", dut.sys_cnt_q, 16'h0080);
        wr(16'hFF04, 8'h3C);
        iAddr = 16'hFF05; #1;
        check("t4_glitch", oRData, 8'h01);
        check("t4_sys0", dut.sys_cnt_q, 0);
        wr(16'hFF07, 8'h03);
        feed(32);
        wr(16'hFF04, 8'h00);
        iAddr = 16'hFF05; #1;
        check("t4_noglitch", oRData, 8'h01);

        // Backlog saturation
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 7, 1'b0, 16'hFF04, 8'h00);
        check("t5_pend", dut.pend_q, 31);
        check("t5_ovr", oOverrun, 1'b1);
        idle(40);
        check("t5_accepted", m_accepted, 36);
        check("t5_sys", dut.sys_cnt_q, 144);
        check("t5_ovr_sticky", oOverrun, 1'b1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 12, 16'(16'hFF03 + $urandom_range(0, 5)),
                8'($urandom));
        end

        // Asynchronous reset while a reload step is pending
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'hFF);
        cyc(1'b1, 7, 1'b0, 16'hFF05, 8'h00);
        idle(4);
        check("t6_irq_before", oInterrupt0x50, 1'b1);
        #1;
        iReset_n = 1'b0;
        #1;
        check("t6_irq_async", oInterrupt0x50, 1'b0);
        check("t6_sys_async", dut.sys_cnt_q, 0);
        check("t6_pend_async", dut.pend_q, 0);
        check("t6_tima_async", oRData, 8'h00);
        model_reset();
        iReset_n = 1'b1;
        iAddr = 16'hFF04; #1;
        check("t6_div", oRData, 8'h00);
        iAddr = 16'hFF05; #1;
        check("t6_tima", oRData, 8'h00);
        iAddr = 16'hFF06; #1;
        check("t6_tma", oRData, 8'h00);
        iAddr = 16'hFF07; #1;
        check("t6_tac", oRData, 8'hF8);
        idle(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
